// File: rtl/leds_rgb_seq.sv
// Line-synchronous R/G/B exposure sequencer driving the START/END/RGB controls of leds_rgb_pwm.
// Every output is a registered decode of the sequencer state, so it appears one cycle after that state.
module leds_rgb_seq #(
  parameter int EXPO_W = 16,
  parameter int GAP_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              LINE_TRIG,
  input  logic [2:0]        COLOR_EN,
  input  logic [EXPO_W-1:0] EXPO_R,
  input  logic [EXPO_W-1:0] EXPO_G,
  input  logic [EXPO_W-1:0] EXPO_B,
  input  logic [GAP_W-1:0]  GAP,
  input  logic              CLR_OVR,
  output logic              START,
  output logic              END,
  output logic [2:0]        RGB,
  output logic              BUSY,
  output logic              LINE_DONE,
  output logic              OVERRUN
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_ON    = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        col_q, col_d;
  logic [2:0]        rem_q, rem_d;
  logic [EXPO_W-1:0] expo_r_q, expo_r_d;
  logic [EXPO_W-1:0] expo_g_q, expo_g_d;
  logic [EXPO_W-1:0] expo_b_q, expo_b_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [EXPO_W-1:0] ecnt_q, ecnt_d;
  logic [GAP_W-1:0]  gcnt_q, gcnt_d;
  logic              ovr_q, ovr_d;

  logic              start_q, start_d;
  logic              end_q, end_d;
  logic [2:0]        rgb_q, rgb_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovr_out_q;

  logic [2:0]        act_s;
  logic [2:0]        first_s;
  logic [2:0]        next_s;
  logic              busy_s;
  logic [EXPO_W-1:0] expo_sel_s;

  // Highest-priority colour of a mask, in R, G, B order.
  function automatic logic [2:0] first_col(input logic [2:0] m);
    if (m[2]) begin
      first_col = 3'b100;
    end else if (m[1]) begin
      first_col = 3'b010;
    end else if (m[0]) begin
      first_col = 3'b001;
    end else begin
      first_col = 3'b000;
    end
  endfunction

  // Next-state, counters, shadow capture and output decode.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    rem_d    = rem_q;
    expo_r_d = expo_r_q;
    expo_g_d = expo_g_q;
    expo_b_d = expo_b_q;
    gap_d    = gap_q;
    ecnt_d   = ecnt_q;
    gcnt_d   = gcnt_q;

    act_s      = COLOR_EN & {(EXPO_R != {EXPO_W{1'b0}}), (EXPO_G != {EXPO_W{1'b0}}),
                             (EXPO_B != {EXPO_W{1'b0}})};
    first_s    = first_col(act_s);
    next_s     = first_col(rem_q);
    busy_s     = (state_q == S_SETUP) || (state_q == S_ON) || (state_q == S_GAP);
    expo_sel_s = col_q[2] ? expo_r_q : (col_q[1] ? expo_g_q : expo_b_q);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (LINE_TRIG) begin
          expo_r_d = EXPO_R;
          expo_g_d = EXPO_G;
          expo_b_d = EXPO_B;
          gap_d    = GAP;
          col_d    = first_s;
          rem_d    = act_s & ~first_s;
          if (act_s != 3'b000) begin
            state_d = S_SETUP;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        ecnt_d  = expo_sel_s;
        state_d = S_ON;
      end
      S_ON: begin
        if (ecnt_q == {EXPO_W{1'b0}}) begin
          if (rem_q != 3'b000) begin
            // Colour advances here; RGB is blank through the gap so the early switch is invisible.
            col_d = next_s;
            rem_d = rem_q & ~next_s;
            if (gap_q != {GAP_W{1'b0}}) begin
              gcnt_d  = gap_q;
              state_d = S_GAP;
            end else begin
              state_d = S_SETUP;
            end
          end else begin
            state_d = S_DONE;
          end
        end else begin
          ecnt_d = ecnt_q - {{(EXPO_W-1){1'b0}}, 1'b1};
        end
      end
      S_GAP: begin
        if (gcnt_q == {{(GAP_W-1){1'b0}}, 1'b1}) begin
          state_d = S_SETUP;
        end else begin
          gcnt_d = gcnt_q - {{(GAP_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The counter holds EXPO only in the first ON cycle because EXPO is never zero here.
    start_d = (state_q == S_ON) && (ecnt_q == expo_sel_s);
    end_d   = (state_q == S_ON) && (ecnt_q == {EXPO_W{1'b0}});
    rgb_d   = ((state_q == S_SETUP) || (state_q == S_ON)) ? col_q : 3'b000;
    busy_d  = busy_s;
    done_d  = (state_q == S_DONE);

    if (LINE_TRIG && busy_s) begin
      ovr_d = 1'b1;
    end else if (CLR_OVR) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // State, shadow and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      col_q     <= 3'b000;
      rem_q     <= 3'b000;
      expo_r_q  <= {EXPO_W{1'b0}};
      expo_g_q  <= {EXPO_W{1'b0}};
      expo_b_q  <= {EXPO_W{1'b0}};
      gap_q     <= {GAP_W{1'b0}};
      ecnt_q    <= {EXPO_W{1'b0}};
      gcnt_q    <= {GAP_W{1'b0}};
      ovr_q     <= 1'b0;
      start_q   <= 1'b0;
      end_q     <= 1'b0;
      rgb_q     <= 3'b000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      rem_q     <= rem_d;
      expo_r_q  <= expo_r_d;
      expo_g_q  <= expo_g_d;
      expo_b_q  <= expo_b_d;
      gap_q     <= gap_d;
      ecnt_q    <= ecnt_d;
      gcnt_q    <= gcnt_d;
      ovr_q     <= ovr_d;
      start_q   <= start_d;
      end_q     <= end_d;
      rgb_q     <= rgb_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovr_out_q <= ovr_q;
    end
  end

  assign START     = start_q;
  assign END       = end_q;
  assign RGB       = rgb_q;
  assign BUSY      = busy_q;
  assign LINE_DONE = done_q;
  assign OVERRUN   = ovr_out_q;

endmodule
